// File: rtl/riscv_state_pkg.sv
// Shared types for the EX-stage scheduler: functional-unit tags and FSM states.
package riscv_state_pkg;

  localparam int unsigned UNIT_W  = 2;
  localparam int unsigned STATE_W = 2;

  // Functional unit an issued instruction targets
  typedef enum logic [UNIT_W-1:0] {
    U_NONE = 2'd0,
    U_ALU  = 2'd1,
    U_MDU  = 2'd2
  } unit_t;

  // Scheduler states: IDLE accepts work, BUSY waits for the MDU, DRAIN discards a flushed MDU result
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/riscv_ex_sched.sv
// EX-stage scheduler: steers work to the ALU or the multi-cycle MDU, stalls ID/EX while the
// MDU is busy, muxes the WB result and drains MDU work that was flushed by a WB exception.
module riscv_ex_sched
  import riscv_state_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned MDU_MAX_CYCLES = 64
) (
  input  logic            rst_ni,
  input  logic            clk_i,
  input  logic            id_bubble_i,
  input  unit_t           id_unit_i,
  input  logic            wb_stall_i,
  input  logic            wb_exception_i,
  input  logic [XLEN-1:0] alu_r_i,
  input  logic            alu_bubble_i,
  output logic            mdu_req_o,
  input  logic            mdu_ack_i,
  input  logic [XLEN-1:0] mdu_r_i,
  output logic            ex_stall_o,
  output logic [XLEN-1:0] ex_r_o,
  output logic            ex_bubble_o,
  output logic            ex_mdu_timeout_o
);

  localparam int unsigned     CNT_W   = $clog2(MDU_MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MDU_MAX_CYCLES);

  sched_state_t    state_q, state_d;
  unit_t           sel_q, sel_d;
  logic [XLEN-1:0] mdu_r_q, mdu_r_d;
  logic            mdu_bubble_q, mdu_bubble_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic            mdu_req_q, mdu_req_d;
  logic            timeout_q, timeout_d;
  logic            issue_mdu;

  // Issue decode and EX stall; stall covers the issue cycle and every non-IDLE cycle
  always_comb begin
    issue_mdu  = (state_q == IDLE) && !id_bubble_i && (id_unit_i == U_MDU) &&
                 !wb_stall_i && !wb_exception_i;
    ex_stall_o = wb_stall_i || issue_mdu || (state_q != IDLE);
    cnt_inc    = cnt_q + CNT_W'(1);
  end

  // Next-state and datapath update for the scheduler FSM
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    mdu_r_d      = mdu_r_q;
    mdu_bubble_d = mdu_bubble_q;
    cnt_d        = cnt_q;
    mdu_req_d    = 1'b0;
    timeout_d    = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (issue_mdu) begin
          // MDU result slot shows a bubble until the new result lands
          mdu_req_d    = 1'b1;
          cnt_d        = '0;
          sel_d        = U_MDU;
          mdu_bubble_d = 1'b1;
          state_d      = BUSY;
        end else if (!ex_stall_o) begin
          // Whatever was on ex_r_o has been consumed; return the mux to the ALU
          sel_d        = U_ALU;
          mdu_bubble_d = 1'b1;
        end
      end

      BUSY: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) timeout_d = 1'b1;
        end
        if (wb_exception_i) begin
          state_d = mdu_ack_i ? IDLE : DRAIN;
        end else if (mdu_ack_i) begin
          mdu_r_d      = mdu_r_i;
          mdu_bubble_d = 1'b0;
          sel_d        = U_MDU;
          state_d      = IDLE;
        end
      end

      DRAIN: begin
        // The MDU cannot be aborted, so its flushed result is swallowed here
        if (mdu_ack_i) begin
          mdu_bubble_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush always kills any pending MDU result
    if (wb_exception_i) mdu_bubble_d = 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Result select, captured MDU result, timeout counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q        <= U_ALU;
      mdu_r_q      <= '0;
      mdu_bubble_q <= 1'b1;
      cnt_q        <= '0;
      mdu_req_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      mdu_r_q      <= mdu_r_d;
      mdu_bubble_q <= mdu_bubble_d;
      cnt_q        <= cnt_d;
      mdu_req_q    <= mdu_req_d;
      timeout_q    <= timeout_d;
    end
  end

  // WB result mux
  always_comb begin
    ex_r_o      = (sel_q == U_MDU) ? mdu_r_q      : alu_r_i;
    ex_bubble_o = (sel_q == U_MDU) ? mdu_bubble_q : alu_bubble_i;
  end

  assign mdu_req_o        = mdu_req_q;
  assign ex_mdu_timeout_o = timeout_q;

endmodule

// File: tb/tb_riscv_ex_sched.sv
// Self-checking bench for riscv_ex_sched: WB results are scoreboarded, control outputs checked per cycle.
module tb_riscv_ex_sched;
  import riscv_state_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned MAXC = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            id_bubble_i;
  unit_t           id_unit_i;
  logic            wb_stall_i;
  logic            wb_exception_i;
  logic [XLEN-1:0] alu_r_i;
  logic            alu_bubble_i;
  logic            mdu_req_o;
  logic            mdu_ack_i;
  logic [XLEN-1:0] mdu_r_i;
  logic            ex_stall_o;
  logic [XLEN-1:0] ex_r_o;
  logic            ex_bubble_o;
  logic            ex_mdu_timeout_o;

  always #5 clk_i = ~clk_i;

  riscv_ex_sched #(.XLEN(XLEN), .MDU_MAX_CYCLES(MAXC)) dut (
    .rst_ni           (rst_ni),
    .clk_i            (clk_i),
    .id_bubble_i      (id_bubble_i),
    .id_unit_i        (id_unit_i),
    .wb_stall_i       (wb_stall_i),
    .wb_exception_i   (wb_exception_i),
    .alu_r_i          (alu_r_i),
    .alu_bubble_i     (alu_bubble_i),
    .mdu_req_o        (mdu_req_o),
    .mdu_ack_i        (mdu_ack_i),
    .mdu_r_i          (mdu_r_i),
    .ex_stall_o       (ex_stall_o),
    .ex_r_o           (ex_r_o),
    .ex_bubble_o      (ex_bubble_o),
    .ex_mdu_timeout_o (ex_mdu_timeout_o)
  );

  int unsigned     n_checks = 0;
  int unsigned     n_errors = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every non-bubble result WB accepts must match the oldest expected value
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && ex_bubble_o === 1'b0 && !wb_stall_i && !wb_exception_i) begin
      if (exp_q.size() == 0) chk("wb_unexpected_pending", XLEN'(exp_q.size()), XLEN'(1));
      else                   chk("wb_data", ex_r_o, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic id_idle();
    id_bubble_i = 1'b1;
    id_unit_i   = U_NONE;
  endtask

  task automatic issue_cycle(input bit hold_id);
    id_bubble_i = 1'b0;
    id_unit_i   = U_MDU;
    @(negedge clk_i);
    chk("issue_stall", XLEN'(ex_stall_o), XLEN'(1));
    chk("issue_req", XLEN'(mdu_req_o), XLEN'(0));
    tick();
    if (!hold_id) id_idle();
  endtask

  task automatic busy_wait(input int n, input bit first);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      chk("busy_stall", XLEN'(ex_stall_o), XLEN'(1));
      chk("busy_req", XLEN'(mdu_req_o), XLEN'(first && k == 0));
      chk("busy_bubble", XLEN'(ex_bubble_o), XLEN'(1));
      tick();
    end
  endtask

  task automatic ack_cycle(input logic [XLEN-1:0] r, input bit keep, input bit first);
    mdu_ack_i = 1'b1;
    mdu_r_i   = r;
    if (keep) exp_q.push_back(r);
    @(negedge clk_i);
    chk("ack_stall", XLEN'(ex_stall_o), XLEN'(1));
    chk("ack_req", XLEN'(mdu_req_o), XLEN'(first));
    tick();
    mdu_ack_i = 1'b0;
    mdu_r_i   = '0;
  endtask

  task automatic alu_cycle(input logic [XLEN-1:0] v);
    id_bubble_i  = 1'b0;
    id_unit_i    = U_ALU;
    alu_r_i      = v;
    alu_bubble_i = 1'b0;
    exp_q.push_back(v);
    @(negedge clk_i);
    chk("alu_stall", XLEN'(ex_stall_o), XLEN'(0));
    chk("alu_req", XLEN'(mdu_req_o), XLEN'(0));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni         = 1'b0;
    id_idle();
    wb_stall_i     = 1'b0;
    wb_exception_i = 1'b0;
    alu_r_i        = '0;
    alu_bubble_i   = 1'b1;
    mdu_ack_i      = 1'b0;
    mdu_r_i        = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_stall", XLEN'(ex_stall_o), XLEN'(0));
    chk("rst_req", XLEN'(mdu_req_o), XLEN'(0));
    chk("rst_timeout", XLEN'(ex_mdu_timeout_o), XLEN'(0));
    chk("rst_bubble", XLEN'(ex_bubble_o), XLEN'(1));
    chk("rst_r", ex_r_o, alu_r_i);
    tick();
    rst_ni = 1'b1;
    tick();

    // ALU stream passes straight through without stalls
    alu_cycle(32'h0000_0005);
    alu_cycle(32'hA5A5_0001);
    alu_cycle(32'h7FFF_FFFF);
    alu_bubble_i = 1'b1;
    id_idle();

    // Basic MDU op: ack on the 4th busy cycle, result the cycle after
    issue_cycle(1'b0);
    busy_wait(3, 1'b1);
    ack_cycle(32'h0000_1234, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("mdu_done_stall", XLEN'(ex_stall_o), XLEN'(0));
    chk("mdu_done_bubble", XLEN'(ex_bubble_o), XLEN'(0));
    chk("mdu_done_r", ex_r_o, 32'h0000_1234);
    tick();
    @(negedge clk_i);
    chk("mdu_no_dup", XLEN'(ex_bubble_o), XLEN'(1));
    tick();

    // Flush while busy: drain until the MDU acks, then drop its result
    issue_cycle(1'b0);
    busy_wait(1, 1'b1);
    wb_exception_i = 1'b1;
    @(negedge clk_i);
    chk("exc_stall", XLEN'(ex_stall_o), XLEN'(1));
    tick();
    wb_exception_i = 1'b0;
    busy_wait(3, 1'b0);
    ack_cycle(32'h0000_DEAD, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("drain_stall", XLEN'(ex_stall_o), XLEN'(0));
    chk("drain_bubble", XLEN'(ex_bubble_o), XLEN'(1));
    tick();

    // Ack while WB stalls: result captured and held until WB accepts it once
    issue_cycle(1'b0);
    busy_wait(2, 1'b1);
    wb_stall_i = 1'b1;
    ack_cycle(32'h0000_BEEF, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("wbst_stall", XLEN'(ex_stall_o), XLEN'(1));
      chk("wbst_r", ex_r_o, 32'h0000_BEEF);
      chk("wbst_bubble", XLEN'(ex_bubble_o), XLEN'(0));
      tick();
    end
    wb_stall_i = 1'b0;
    @(negedge clk_i);
    chk("wbst_release_stall", XLEN'(ex_stall_o), XLEN'(0));
    chk("wbst_release_r", ex_r_o, 32'h0000_BEEF);
    tick();
    @(negedge clk_i);
    chk("wbst_no_dup", XLEN'(ex_bubble_o), XLEN'(1));
    tick();

    // Back-to-back MDU ops: second request the cycle after the first result leaves
    issue_cycle(1'b1);
    busy_wait(2, 1'b1);
    ack_cycle(32'h0000_1111, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("b2b_issue_stall", XLEN'(ex_stall_o), XLEN'(1));
    chk("b2b_issue_req", XLEN'(mdu_req_o), XLEN'(0));
    chk("b2b_first_r", ex_r_o, 32'h0000_1111);
    chk("b2b_first_bubble", XLEN'(ex_bubble_o), XLEN'(0));
    tick();
    id_idle();
    busy_wait(1, 1'b1);
    ack_cycle(32'h0000_2222, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("b2b_done_stall", XLEN'(ex_stall_o), XLEN'(0));
    tick();

    // Spurious ack in IDLE is ignored
    mdu_ack_i = 1'b1;
    mdu_r_i   = 32'h0000_0BAD;
    @(negedge clk_i);
    chk("spur_stall", XLEN'(ex_stall_o), XLEN'(0));
    tick();
    mdu_ack_i = 1'b0;
    mdu_r_i   = '0;
    @(negedge clk_i);
    chk("spur_stall2", XLEN'(ex_stall_o), XLEN'(0));
    chk("spur_bubble", XLEN'(ex_bubble_o), XLEN'(1));
    tick();

    // MDU op presented during a flush is not issued
    id_bubble_i    = 1'b0;
    id_unit_i      = U_MDU;
    wb_exception_i = 1'b1;
    @(negedge clk_i);
    chk("excidle_stall", XLEN'(ex_stall_o), XLEN'(0));
    tick();
    wb_exception_i = 1'b0;
    id_idle();
    @(negedge clk_i);
    chk("excidle_req", XLEN'(mdu_req_o), XLEN'(0));
    chk("excidle_stall2", XLEN'(ex_stall_o), XLEN'(0));
    tick();

    // Timeout: no ack ever; flag rises on cycle 9 after issue and stays until reset
    @(negedge clk_i);
    chk("to_pre", XLEN'(ex_mdu_timeout_o), XLEN'(0));
    tick();
    issue_cycle(1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      chk("to_flag", XLEN'(ex_mdu_timeout_o), XLEN'(k >= 9));
      chk("to_stall", XLEN'(ex_stall_o), XLEN'(1));
      tick();
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("to_rst_flag", XLEN'(ex_mdu_timeout_o), XLEN'(0));
    chk("to_rst_stall", XLEN'(ex_stall_o), XLEN'(0));
    chk("to_rst_req", XLEN'(mdu_req_o), XLEN'(0));
    tick();
    rst_ni = 1'b1;
    tick();

    // Normal operation resumes after the abandoned op
    alu_cycle(32'h0000_0077);
    alu_bubble_i = 1'b1;
    id_idle();
    @(negedge clk_i);
    chk("post_rst_stall", XLEN'(ex_stall_o), XLEN'(0));
    tick();

    chk("sb_empty", XLEN'(exp_q.size()), XLEN'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
